branch_head_tracker: RTL and testbench
======================================

Name: branch_head_tracker

Overview:
- Consumer-side counterpart of the decode-time branch epoch generator.
- Holds the outstanding (unresolved) branch epochs in program order and retires them in order as execute resolves them out of order.
- Squashes younger branches on a mispredict.
- Publishes the oldest unresolved branch epoch, a {wrap, index} pair. This is the visibility point that the younger-than comparators and the taint/untaint logic consume.

Parameters:
- YROT_WIDTH, 9: ROB index width. Epochs are YROT_WIDTH+1 bits, with the MSB as the wrap bit.
- NUM_DECODE, 4: maximum branch allocations per cycle.
- NUM_RESOLVE, 2: resolve ports per cycle.
- BR_DEPTH, 16: outstanding-branch ring capacity. Must be a power of 2 and at least NUM_DECODE.
- MAX_RETIRE, 2: maximum head pops per cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- alloc_vec  in  NUM_DECODE  per-slot branch-allocate strobe. Slot 0 is the oldest.
- alloc_epoch  in  NUM_DECODE*(YROT_WIDTH+1)  packed epoch per slot. Slot i is at bits [i*(YROT_WIDTH+1) +: YROT_WIDTH+1].
- alloc_ready  out  1  at least NUM_DECODE ring slots are free.
- resolve_valid  in  NUM_RESOLVE  resolve strobes.
- resolve_epoch  in  NUM_RESOLVE*(YROT_WIDTH+1)  packed epochs of the branches being resolved.
- squash_valid  in  1  mispredict.
- squash_epoch  in  YROT_WIDTH+1  epoch of the mispredicted branch.
- vp_valid  out  1  at least one branch is outstanding.
- vp_epoch  out  YROT_WIDTH+1  epoch of the oldest outstanding branch.
- count  out  $clog2(BR_DEPTH)+1  occupancy.
- err_overflow  out  1  sticky: an allocation arrived while alloc_ready=0.
- err_nomatch  out  1  sticky: a squash or resolve matched no live entry.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - head=0, tail=0, count=0.
  - All valid and resolved bits cleared.
  - vp_valid=0, vp_epoch=0, alloc_ready=1, err_overflow=0, err_nomatch=0.
  - Reset asserted mid-operation discards all state immediately.
- Ring state:
  - BR_DEPTH entries, each {valid, resolved, epoch}.
  - Head and tail pointers are $clog2(BR_DEPTH) bits, wrapping modulo BR_DEPTH.
- Allocation:
  - The set slots of alloc_vec are compacted in slot order and written at tail, tail+1, ... with resolved=0.
  - tail advances by popcount(alloc_vec).
  - alloc_ready = (BR_DEPTH - count) >= NUM_DECODE, computed from registered count.
  - If alloc_vec!=0 while alloc_ready=0, the whole allocation is dropped and err_overflow is set.
- Resolve:
  - Each valid resolve port CAM-matches epoch against the live entries and sets that entry's resolved bit at the clock edge.
  - If a port matches nothing, err_nomatch is set and the port has no other effect.
  - Two ports naming the same epoch behave as one.
- Retire:
  - Each cycle, pop the maximal run of consecutive valid and resolved entries starting at head, capped at MAX_RETIRE.
  - Pop decisions use registered resolved bits, so a resolve in cycle t can pop at the end of cycle t+1.
  - vp_epoch and vp_valid then update in cycle t+2.
- Squash:
  - squash_epoch is CAM-matched. The matched entry k is marked resolved.
  - Every entry younger than k (ring positions k+1 .. tail-1) is invalidated, and tail is set to k+1.
  - Ordering is by ring position; no epoch comparison is performed.
  - If there is no match, squash is ignored and err_nomatch is set.
- Simultaneous events:
  - Squash overrides allocation in the same cycle; the allocation is dropped and err_overflow is not set.
  - A resolve that targets an entry squashed in the same cycle is ignored.
  - A resolve that targets entry k itself is harmless.
  - Retire and squash in the same cycle: pops apply from head, and squash truncation applies to tail. If pops reach k they may include k.
  - Occupancy: count_next = count + allocated - popped - squashed. Allocation in the same cycle as a pop uses the pre-pop alloc_ready.
- Outputs:
  - vp_valid = (count != 0).
  - vp_epoch = epoch at head when vp_valid=1. When empty, vp_epoch holds its last value.
  - All outputs are registered or derive from registered state; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro RESOLVE_BYPASS_EN.
- Defined: resolve CAM hits are ORed into the retire-run logic combinationally. A resolve in cycle t can pop at the end of cycle t, and vp_epoch updates in cycle t+1.
- Undefined: the two-cycle path described above.
- Squash and error behaviour are identical in both builds.

Test Plan:
- Reset, then allocate alloc_vec=4'b1010 with slot1=10'h005 and slot3=10'h007 → next cycle count=2, vp_valid=1, vp_epoch=10'h005.
- Resolve 10'h007 then 10'h005 on consecutive cycles → vp_epoch remains 10'h005 until both are resolved. Then both pop in one cycle (MAX_RETIRE=2): count=0, vp_valid=0.
- Allocate epochs 10'h1FE, 10'h1FF, 10'h200, 10'h201 (index wraps, wrap bit flips); resolve 10'h1FE and 10'h1FF → vp_epoch=10'h200. Repeat until ring pointers wrap past BR_DEPTH; order is preserved.
- With 5 outstanding branches, squash the 2nd with same-cycle alloc_vec=4'b0001 → count=2 after pops, allocation dropped, err_overflow=0, tail=head+2.
- With 13 entries, alloc_vec=4'b1111 → alloc_ready=0, allocation dropped, err_overflow=1 (sticky), count=13. Resolve epoch 10'h3AA, which is absent → err_nomatch=1.
- With RESOLVE_BYPASS_EN defined, resolve the head in cycle t → vp_epoch advances in cycle t+1, versus t+2 without the macro.

Source files
------------

// File: rtl/branch_head_tracker.sv
// Outstanding-branch ring: tracks unresolved branch epochs in program order,
// retires them in order as execute resolves them, truncates on mispredict and
// publishes the oldest unresolved epoch {wrap, index} as the visibility point.
// Optional build macro: RESOLVE_BYPASS_EN (same-cycle resolve feeds retire).
module branch_head_tracker #(
    parameter int unsigned YROT_WIDTH  = 9,
    parameter int unsigned NUM_DECODE  = 4,
    parameter int unsigned NUM_RESOLVE = 2,
    parameter int unsigned BR_DEPTH    = 16,
    parameter int unsigned MAX_RETIRE  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_DECODE-1:0]                 alloc_vec,
    input  logic [NUM_DECODE*(YROT_WIDTH+1)-1:0]  alloc_epoch,
    output logic                                  alloc_ready,
    input  logic [NUM_RESOLVE-1:0]                resolve_valid,
    input  logic [NUM_RESOLVE*(YROT_WIDTH+1)-1:0] resolve_epoch,
    input  logic                                  squash_valid,
    input  logic [YROT_WIDTH:0]                   squash_epoch,
    output logic                                  vp_valid,
    output logic [YROT_WIDTH:0]                   vp_epoch,
    output logic [$clog2(BR_DEPTH):0]             count,
    output logic                                  err_overflow,
    output logic                                  err_nomatch
);

    localparam int unsigned EPOCH_W = YROT_WIDTH + 1;
    localparam int unsigned PTR_W   = $clog2(BR_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    // Registered ring and pointer state
    logic [BR_DEPTH-1:0] valid_q, resolved_q;
    logic [EPOCH_W-1:0]  epoch_q [BR_DEPTH];
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]    count_q;
    logic                alloc_ready_q, vp_valid_q, ovf_q, nom_q;
    logic [EPOCH_W-1:0]  vp_epoch_q;

    // Next-state values
    logic [BR_DEPTH-1:0] valid_n, resolved_n;
    logic [EPOCH_W-1:0]  epoch_n [BR_DEPTH];
    logic [PTR_W-1:0]    head_n, tail_n;
    logic [CNT_W-1:0]    count_n;
    logic                alloc_ready_n, vp_valid_n;
    logic [EPOCH_W-1:0]  vp_epoch_n;

    // CAM / retire / squash intermediates
    logic [BR_DEPTH-1:0] port_hit [NUM_RESOLVE];
    logic [BR_DEPTH-1:0] res_hit, sq_match, retire_res;
    logic [NUM_RESOLVE-1:0] res_miss;
    logic                sq_found, run, alloc_do, ovf_set;
    logic [PTR_W-1:0]    sq_off, sq_idx;
    logic [CNT_W-1:0]    sq_n, pop_n, wr_off;

    // Resolve and squash CAM lookups against live entries
    always_comb begin
        res_hit  = '0;
        res_miss = '0;
        sq_match = '0;
        for (int p = 0; p < NUM_RESOLVE; p++) begin
            port_hit[p] = '0;
            for (int e = 0; e < BR_DEPTH; e++) begin
                port_hit[p][e] = resolve_valid[p] && valid_q[e] &&
                                 (epoch_q[e] == resolve_epoch[p*EPOCH_W +: EPOCH_W]);
            end
            res_hit     = res_hit | port_hit[p];
            res_miss[p] = resolve_valid[p] && (port_hit[p] == '0);
        end
        for (int e = 0; e < BR_DEPTH; e++) begin
            sq_match[e] = squash_valid && valid_q[e] && (epoch_q[e] == squash_epoch);
        end
    end

`ifdef RESOLVE_BYPASS_EN
    // Same-cycle resolve hits may retire immediately
    assign retire_res = resolved_q | res_hit;
`else
    // Retire only on resolved bits captured in an earlier cycle
    assign retire_res = resolved_q;
`endif

    // Locate the oldest squash match by ring position from head
    always_comb begin
        sq_found = 1'b0;
        sq_off   = '0;
        for (int off = 0; off < BR_DEPTH; off++) begin
            if (!sq_found && sq_match[PTR_W'(head_q + PTR_W'(off))]) begin
                sq_found = 1'b1;
                sq_off   = PTR_W'(off);
            end
        end
        sq_idx = PTR_W'(head_q + sq_off);
        sq_n   = sq_found ? CNT_W'(count_q - CNT_W'(sq_off) - CNT_W'(1)) : '0;
    end

    // In-order retire run from head; never past the squash point
    always_comb begin
        pop_n = '0;
        run   = 1'b1;
        for (int off = 0; off < MAX_RETIRE; off++) begin
            if (run && valid_q[PTR_W'(head_q + PTR_W'(off))] &&
                retire_res[PTR_W'(head_q + PTR_W'(off))] &&
                (!sq_found || (CNT_W'(off) <= CNT_W'(sq_off)))) begin
                pop_n = pop_n + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Allocation gating: squash wins over allocation and suppresses overflow
    assign alloc_do = (alloc_vec != '0) && alloc_ready_q && !sq_found;
    assign ovf_set  = (alloc_vec != '0) && !alloc_ready_q && !sq_found;

    // Ring next state: resolve, squash truncation, pops, compacted allocation
    always_comb begin
        valid_n    = valid_q;
        resolved_n = resolved_q | res_hit;
        epoch_n    = epoch_q;
        head_n     = PTR_W'(head_q + PTR_W'(pop_n));
        tail_n     = tail_q;
        wr_off     = '0;

        if (sq_found) begin
            resolved_n[sq_idx] = 1'b1;
            for (int off = 0; off < BR_DEPTH; off++) begin
                if ((CNT_W'(off) > CNT_W'(sq_off)) && (CNT_W'(off) < count_q)) begin
                    valid_n[PTR_W'(head_q + PTR_W'(off))]    = 1'b0;
                    resolved_n[PTR_W'(head_q + PTR_W'(off))] = 1'b0;
                end
            end
            tail_n = PTR_W'(sq_idx + PTR_W'(1));
        end

        for (int off = 0; off < MAX_RETIRE; off++) begin
            if (CNT_W'(off) < pop_n) begin
                valid_n[PTR_W'(head_q + PTR_W'(off))]    = 1'b0;
                resolved_n[PTR_W'(head_q + PTR_W'(off))] = 1'b0;
            end
        end

        if (alloc_do) begin
            for (int i = 0; i < NUM_DECODE; i++) begin
                if (alloc_vec[i]) begin
                    valid_n[PTR_W'(tail_q + PTR_W'(wr_off))]    = 1'b1;
                    resolved_n[PTR_W'(tail_q + PTR_W'(wr_off))] = 1'b0;
                    epoch_n[PTR_W'(tail_q + PTR_W'(wr_off))]    = alloc_epoch[i*EPOCH_W +: EPOCH_W];
                    wr_off = wr_off + CNT_W'(1);
                end
            end
            tail_n = PTR_W'(tail_q + PTR_W'(wr_off));
        end

        count_n       = CNT_W'(count_q + wr_off - pop_n - sq_n);
        alloc_ready_n = (CNT_W'(BR_DEPTH) - count_n) >= CNT_W'(NUM_DECODE);
        vp_valid_n    = (count_n != '0);
        vp_epoch_n    = (count_n != '0) ? epoch_n[head_n] : vp_epoch_q;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            resolved_q    <= '0;
            for (int e = 0; e < BR_DEPTH; e++) epoch_q[e] <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            alloc_ready_q <= 1'b1;
            vp_valid_q    <= 1'b0;
            vp_epoch_q    <= '0;
            ovf_q         <= 1'b0;
            nom_q         <= 1'b0;
        end else begin
            valid_q       <= valid_n;
            resolved_q    <= resolved_n;
            epoch_q       <= epoch_n;
            head_q        <= head_n;
            tail_q        <= tail_n;
            count_q       <= count_n;
            alloc_ready_q <= alloc_ready_n;
            vp_valid_q    <= vp_valid_n;
            vp_epoch_q    <= vp_epoch_n;
            ovf_q         <= ovf_q | ovf_set;
            nom_q         <= nom_q | (res_miss != '0) | (squash_valid && !sq_found);
        end
    end

    assign alloc_ready  = alloc_ready_q;
    assign vp_valid     = vp_valid_q;
    assign vp_epoch     = vp_epoch_q;
    assign count        = count_q;
    assign err_overflow = ovf_q;
    assign err_nomatch  = nom_q;

endmodule

// File: tb/tb_branch_head_tracker.sv
// Directed table-driven bench for branch_head_tracker (default parameters).
module tb_branch_head_tracker;

`ifdef RESOLVE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  alloc_vec;
    logic [39:0] alloc_epoch;
    logic        alloc_ready;
    logic [1:0]  resolve_valid;
    logic [19:0] resolve_epoch;
    logic        squash_valid;
    logic [9:0]  squash_epoch;
    logic        vp_valid;
    logic [9:0]  vp_epoch;
    logic [4:0]  count;
    logic        err_overflow;
    logic        err_nomatch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_head_tracker dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_vec(alloc_vec), .alloc_epoch(alloc_epoch), .alloc_ready(alloc_ready),
        .resolve_valid(resolve_valid), .resolve_epoch(resolve_epoch),
        .squash_valid(squash_valid), .squash_epoch(squash_epoch),
        .vp_valid(vp_valid), .vp_epoch(vp_epoch), .count(count),
        .err_overflow(err_overflow), .err_nomatch(err_nomatch)
    );

    typedef struct {
        logic [3:0]  av;
        logic [39:0] ae;
        logic [1:0]  rv;
        logic [19:0] re;
        logic        sv;
        logic [9:0]  se;
        logic [4:0]  c;
        logic        vv;
        logic [9:0]  ve;
        logic        rdy;
        logic        ovf;
        logic        nom;
        bit          skb;  // post-edge state differs when resolve bypass is built in
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] av, input logic [9:0] e0, e1, e2, e3,
                       input logic [1:0] rv, input logic [9:0] r0, r1,
                       input logic sv, input logic [9:0] se,
                       input logic [4:0] c, input logic vv, input logic [9:0] ve,
                       input logic rdy, ovf, nom, input bit skb);
        vec_t v;
        v.av = av; v.ae = {e3, e2, e1, e0};
        v.rv = rv; v.re = {r1, r0};
        v.sv = sv; v.se = se;
        v.c = c; v.vv = vv; v.ve = ve; v.rdy = rdy; v.ovf = ovf; v.nom = nom;
        v.skb = skb;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, "_count"}, 32'(count), 32'(v.c));
        check({tag, "_vp_valid"}, 32'(vp_valid), 32'(v.vv));
        check({tag, "_vp_epoch"}, 32'(vp_epoch), 32'(v.ve));
        check({tag, "_alloc_ready"}, 32'(alloc_ready), 32'(v.rdy));
        check({tag, "_err_overflow"}, 32'(err_overflow), 32'(v.ovf));
        check({tag, "_err_nomatch"}, 32'(err_nomatch), 32'(v.nom));
    endtask

    // Drive one cycle of stimulus, then optionally compare post-edge outputs
    task automatic apply(input vec_t v, input bit do_chk, input string tag);
        alloc_vec     = v.av;
        alloc_epoch   = v.ae;
        resolve_valid = v.rv;
        resolve_epoch = v.re;
        squash_valid  = v.sv;
        squash_epoch  = v.se;
        @(posedge clk);
        #1;
        alloc_vec     = '0;
        resolve_valid = '0;
        squash_valid  = 1'b0;
        if (do_chk) check_outs(tag, v);
    endtask

    initial begin
        vec_t h;
        rst_n = 1'b0;
        alloc_vec = '0; alloc_epoch = '0;
        resolve_valid = '0; resolve_epoch = '0;
        squash_valid = 1'b0; squash_epoch = '0;

        //  av       e0      e1      e2      e3      rv     r0      r1      sv  se      c   vv  ve      rdy ovf nom skb
        add(4'b1010, 10'h0,   10'h005, 10'h0,   10'h007, 2'b00, 10'h0,   10'h0,   0, 10'h0,   2,  1, 10'h005, 1, 0, 0, 0);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b01, 10'h007, 10'h0,   0, 10'h0,   2,  1, 10'h005, 1, 0, 0, 0);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b01, 10'h005, 10'h0,   0, 10'h0,   2,  1, 10'h005, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   0,  0, 10'h005, 1, 0, 0, 0);
        add(4'b1111, 10'h1FE, 10'h1FF, 10'h200, 10'h201, 2'b00, 10'h0,   10'h0,   0, 10'h0,   4,  1, 10'h1FE, 1, 0, 0, 0);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b11, 10'h1FE, 10'h1FF, 0, 10'h0,   4,  1, 10'h1FE, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   2,  1, 10'h200, 1, 0, 0, 0);
        add(4'b1111, 10'h202, 10'h203, 10'h204, 10'h205, 2'b00, 10'h0,   10'h0,   0, 10'h0,   6,  1, 10'h200, 1, 0, 0, 0);
        add(4'b1111, 10'h206, 10'h207, 10'h208, 10'h209, 2'b00, 10'h0,   10'h0,   0, 10'h0,   10, 1, 10'h200, 1, 0, 0, 0);
        add(4'b0011, 10'h20A, 10'h20B, 10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   12, 1, 10'h200, 1, 0, 0, 0);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b11, 10'h200, 10'h201, 0, 10'h0,   12, 1, 10'h200, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b11, 10'h202, 10'h203, 0, 10'h0,   10, 1, 10'h202, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   8,  1, 10'h204, 1, 0, 0, 0);
        add(4'b1111, 10'h20C, 10'h20D, 10'h20E, 10'h20F, 2'b00, 10'h0,   10'h0,   0, 10'h0,   12, 1, 10'h204, 1, 0, 0, 0);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b11, 10'h204, 10'h205, 0, 10'h0,   12, 1, 10'h204, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b11, 10'h206, 10'h207, 0, 10'h0,   10, 1, 10'h206, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b11, 10'h208, 10'h209, 0, 10'h0,   8,  1, 10'h208, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b11, 10'h20A, 10'h20B, 0, 10'h0,   6,  1, 10'h20A, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b11, 10'h20C, 10'h20D, 0, 10'h0,   4,  1, 10'h20C, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   2,  1, 10'h20E, 1, 0, 0, 0);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b11, 10'h20E, 10'h20F, 0, 10'h0,   2,  1, 10'h20E, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   0,  0, 10'h20E, 1, 0, 0, 0);
        add(4'b1111, 10'h300, 10'h301, 10'h302, 10'h303, 2'b00, 10'h0,   10'h0,   0, 10'h0,   4,  1, 10'h300, 1, 0, 0, 0);
        add(4'b0001, 10'h304, 10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   5,  1, 10'h300, 1, 0, 0, 0);
        add(4'b0001, 10'h3FF, 10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   1, 10'h301, 2,  1, 10'h300, 1, 0, 0, 0);
        add(4'b0001, 10'h310, 10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   3,  1, 10'h300, 1, 0, 0, 0);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b11, 10'h300, 10'h301, 0, 10'h0,   3,  1, 10'h300, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   1,  1, 10'h310, 1, 0, 0, 0);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b01, 10'h310, 10'h0,   0, 10'h0,   1,  1, 10'h310, 1, 0, 0, 1);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   0,  0, 10'h310, 1, 0, 0, 0);
        add(4'b1111, 10'h100, 10'h101, 10'h102, 10'h103, 2'b00, 10'h0,   10'h0,   0, 10'h0,   4,  1, 10'h100, 1, 0, 0, 0);
        add(4'b1111, 10'h104, 10'h105, 10'h106, 10'h107, 2'b00, 10'h0,   10'h0,   0, 10'h0,   8,  1, 10'h100, 1, 0, 0, 0);
        add(4'b1111, 10'h108, 10'h109, 10'h10A, 10'h10B, 2'b00, 10'h0,   10'h0,   0, 10'h0,   12, 1, 10'h100, 1, 0, 0, 0);
        add(4'b0001, 10'h10C, 10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   13, 1, 10'h100, 0, 0, 0, 0);
        add(4'b1111, 10'h200, 10'h201, 10'h202, 10'h203, 2'b00, 10'h0,   10'h0,   0, 10'h0,   13, 1, 10'h100, 0, 1, 0, 0);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b01, 10'h3AA, 10'h0,   0, 10'h0,   13, 1, 10'h100, 0, 1, 1, 0);
        add(4'b0000, 10'h0,   10'h0,   10'h0,   10'h0,   2'b00, 10'h0,   10'h0,   0, 10'h0,   13, 1, 10'h100, 0, 1, 1, 0);

        // Reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        h = tbl[0];
        h.c = 0; h.vv = 0; h.ve = 10'h0; h.rdy = 1; h.ovf = 0; h.nom = 0;
        check_outs("reset", h);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], !(tbl[i].skb && BYP), $sformatf("r%0d", i));
        end

        // Asynchronous reset mid-operation clears everything before any edge
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("midreset", h);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Resolve-to-visibility latency: t+2 normally, t+1 with bypass
        h = tbl[0];
        h.av = 4'b0011; h.ae = {10'h0, 10'h0, 10'h0A1, 10'h0A0}; h.rv = '0; h.sv = 0;
        h.c = 2; h.vv = 1; h.ve = 10'h0A0; h.rdy = 1; h.ovf = 0; h.nom = 0;
        apply(h, 1'b1, "lat_alloc");
        h.av = '0; h.rv = 2'b01; h.re = {10'h0, 10'h0A0};
        h.c = BYP ? 5'd1 : 5'd2; h.ve = BYP ? 10'h0A1 : 10'h0A0;
        apply(h, 1'b1, "lat_t1");
        h.rv = '0; h.c = 1; h.ve = 10'h0A1;
        apply(h, 1'b1, "lat_t2");

        // Pop at head and squash truncation in the same cycle
        h.av = 4'b0011; h.ae = {10'h0, 10'h0, 10'h0B1, 10'h0B0};
        h.c = 3; h.ve = 10'h0A1;
        apply(h, 1'b1, "sqpop_alloc");
        h.av = '0; h.rv = 2'b01; h.re = {10'h0, 10'h0A1};
        apply(h, !BYP, "sqpop_res");
        h.rv = '0; h.sv = 1; h.se = 10'h0B0;
        h.c = 1; h.ve = 10'h0B0;
        apply(h, 1'b1, "sqpop_sq");
        h.sv = 0; h.c = 0; h.vv = 0; h.ve = 10'h0B0;
        apply(h, 1'b1, "sqpop_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
